// File: rtl/gcd_result_display_pkg.sv
// Shared types and constants for the GCD result display path.
// Purely declarative: no logic or state.
package gcd_pkg;

  localparam int GCD_WIDTH = 32;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  // Active-low {g,f,e,d,c,b,a}; anything that is not a BCD digit shows blank.
  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/gcd_result_display_bcd_scan_driver.sv
// Time-multiplexed 7-segment scan of a BCD word with leading-zero blanking.
// an/seg are registered one cycle behind the scan index; free-running, no flow control.
module bcd_scan_driver
  import gcd_pkg::*;
#(
  parameter int DIGITS   = 10,
  parameter int DISP     = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [DISP-1:0]       an,
  output logic [6:0]            seg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DISP > 1) ? $clog2(DISP) : 1;

  logic [CW-1:0]     scan_cnt;
  logic [IW-1:0]     scan_idx;
  logic              scan_wrap;
  logic [DIGITS-1:0] blank;
  logic              upper_zero;
  logic [3:0]        digit_sel;
  logic [6:0]        seg_nxt;
  logic [DISP-1:0]   an_nxt;

  assign scan_wrap = (scan_cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IW'(DISP - 1)) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // A digit is blank when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (bcd[4*i +: 4] == 4'd0);
      blank[i]   = upper_zero && (i > 0);
    end
  end

  always_comb begin
    digit_sel = bcd[4*int'(scan_idx) +: 4];
    seg_nxt   = blank[scan_idx] ? SEG_BLANK : seg7_decode(digit_sel);
    an_nxt    = ~(DISP'(1) << scan_idx);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: rtl/gcd_result_display.sv
// Converts each new GCD result to BCD by sequential double-dabble and scans it onto a 7-seg display.
// Result valid WIDTH+1 cycles after the trigger edge; triggers arriving outside IDLE are dropped.
module gcd_result_display
  import gcd_pkg::*;
#(
  parameter int WIDTH    = GCD_WIDTH,
  parameter int DIGITS   = 10,
  parameter int DISP     = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [WIDTH-1:0]      gcd_in,
  input  logic                  stop_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic                  ovf,
  output logic [DISP-1:0]       an,
  output logic [6:0]            seg
);

  localparam int BW   = 4 * DIGITS;
  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // ceil(WIDTH*log10(2)) with log10(2) ~= 0.30103
  if (DIGITS < (WIDTH * 30103 + 99999) / 100000) begin : g_chk_digits
    $fatal(1, "gcd_result_display: DIGITS too small for WIDTH");
  end
  if (DISP > DIGITS || DISP < 1) begin : g_chk_disp
    $fatal(1, "gcd_result_display: DISP must be in 1..DIGITS");
  end
  if (SCAN_DIV < 1) begin : g_chk_scan
    $fatal(1, "gcd_result_display: SCAN_DIV must be >= 1");
  end

  state_t            state, state_nxt;
  logic              stop_d;
  logic              start;
  logic              load;
  logic              last_iter;
  logic [WIDTH-1:0]  shift_q, shift_step;
  logic [BW-1:0]     acc_q, acc_adj, acc_step;
  logic [CNTW-1:0]   cnt_q;
  logic              ovf_nxt;

  assign start     = stop_in & ~stop_d;
  assign last_iter = (cnt_q == CNTW'(WIDTH - 1));

  // One double-dabble step: correct digits >= 5, then shift {acc,shift} left.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_step   = {acc_adj[BW-2:0], shift_q[WIDTH-1]};
    shift_step = {shift_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    ovf_nxt = 1'b0;
    for (int i = DISP; i < DIGITS; i++) begin
      if (acc_step[4*i +: 4] != 4'd0) ovf_nxt = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CONV;
          load      = 1'b1;
        end
      end
      CONV:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stop_d    <= 1'b0;
      shift_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      stop_d    <= stop_in;
      bcd_valid <= 1'b0;
      if (load) begin
        shift_q <= gcd_in;
        acc_q   <= '0;
        cnt_q   <= '0;
        busy    <= 1'b1;
      end else if (state == CONV) begin
        shift_q <= shift_step;
        acc_q   <= acc_step;
        cnt_q   <= cnt_q + CNTW'(1);
        if (last_iter) begin
          bcd_out   <= acc_step;
          ovf       <= ovf_nxt;
          bcd_valid <= 1'b1;
          busy      <= 1'b0;
        end
      end
    end
  end

  bcd_scan_driver #(
    .DIGITS   (DIGITS),
    .DISP     (DISP),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk (clk),
    .clr (clr),
    .bcd (bcd_out),
    .an  (an),
    .seg (seg)
  );

endmodule
